// File: rtl/multi_delay_line.sv
// multi_delay_line: NCH channels of WIDTH-bit samples behind one programmable tap, with fill-tracked valid.
// Optional macro DLY_TAP_RAMP_EN: tap_cur walks toward the loaded tap one step per ce instead of jumping.

module multi_delay_line_lane #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 32,
    parameter int TAPW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    input  logic [TAPW-1:0]  tap,
    output logic [WIDTH-1:0] dout
);
    // Storage has no reset so tools can map it onto shift-register primitives.
    logic [WIDTH-1:0] line [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            line[0] <= din;
            for (int n = 1; n < DEPTH; n++) line[n] <= line[n-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     dout <= '0;
        else if (ce) dout <= line[tap];
    end
endmodule

module multi_delay_line #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 32,
    parameter int NCH   = 2,
    parameter int TAPW  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [TAPW-1:0]      tap_in,
    input  logic                 tap_ld,
    output logic [NCH*WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic [TAPW-1:0]      tap_cur,
    output logic                 tap_busy
);
    localparam logic [TAPW-1:0] TAP_MAX  = TAPW'(DEPTH - 1);
    localparam logic [TAPW:0]   FILL_MAX = (TAPW+1)'(DEPTH);

    logic [TAPW:0]   fill;
    logic [TAPW-1:0] tap_clamp;

    // A power-of-two depth covers the whole tap field, so no clamp is needed.
    if (DEPTH == (1 << TAPW)) begin : g_noclamp
        assign tap_clamp = tap_in;
    end else begin : g_clamp
        assign tap_clamp = (tap_in > TAP_MAX) ? TAP_MAX : tap_in;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        multi_delay_line_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPW(TAPW)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .din  (din[k*WIDTH +: WIDTH]),
            .tap  (tap_cur),
            .dout (dout[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        fill <= '0;
        else if (ce && fill != FILL_MAX) fill <= fill + (TAPW+1)'(1);
    end

    // line[tap_cur] holds a written sample once more than tap_cur shifts have happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     dout_valid <= 1'b0;
        else if (ce) dout_valid <= (fill >= ({1'b0, tap_cur} + (TAPW+1)'(1)));
    end

`ifdef DLY_TAP_RAMP_EN
    logic [TAPW-1:0] tgt;

    // A load only retargets; stepping resumes on the next ce from wherever tap_cur is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt     <= '0;
            tap_cur <= '0;
        end else if (tap_ld) begin
            tgt <= tap_clamp;
        end else if (ce && tap_cur != tgt) begin
            tap_cur <= (tap_cur < tgt) ? tap_cur + TAPW'(1) : tap_cur - TAPW'(1);
        end
    end

    assign tap_busy = (tap_cur != tgt);
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         tap_cur <= '0;
        else if (tap_ld) tap_cur <= tap_clamp;
    end

    assign tap_busy = 1'b0;
`endif
endmodule
